ped_walk_ctrl: RTL and testbench
================================

// Module: ped_walk_ctrl
// PURPOSE
//  Pedestrian crossing controller downstream of traffic_light: consumes the
//  vehicle light code and a raw crosswalk push-button; drives WALK/DONT_WALK
//  lamps and a flash-phase countdown. Walk is granted only on entry to vehicle
//  RED, aborted if vehicle light leaves RED; invalid light codes lock to safe.
// PARAMETERS
//  CLK_PER_SEC  10  clock cycles per second (must be even, >=2)
//  WALK_SEC     4   steady WALK duration, seconds
//  FLASH_SEC    5   flashing DONT_WALK duration, seconds (>=1)
//  DEB_CYC      3   cycles synced button must stay high to count as a press
//  CW           4   countdown width; 2**CW-1 >= FLASH_SEC
// PORTS
//  clk          in   1   system clock, rising edge
//  rstb         in   1   asynchronous reset, active-high
//  light        in   2   vehicle light: 00 RED, 01 GREEN, 10 YELLOW, 11 invalid
//  ped_btn      in   1   raw push-button, asynchronous, active-high
//  walk         out  1   WALK lamp
//  dont_walk    out  1   DONT_WALK lamp (steady or flashing)
//  countdown    out  CW  seconds left in FLASH phase, 0 otherwise
//  req_pending  out  1   a debounced press is latched, awaiting service
//  conflict     out  1   1-cycle pulse: WALK/FLASH aborted by light leaving RED
//  fault        out  1   sticky: invalid light code seen
// BEHAVIOUR
//  Reset (async, rstb=1): state IDLE, walk=0, dont_walk=1, countdown=0,
//   req_pending=0, conflict=0, fault=0, all counters 0, light_q=RED. All outputs registered.
//  Button: 2-flop sync, then counter; press recognised once per high period when
//   synced level high DEB_CYC consecutive cycles -> req_pending=1 at edge
//   2+DEB_CYC after ped_btn rises. Highs shorter than DEB_CYC ignored.
//  red_entry = (light==00) && (light_q!=00); light_q = light registered each cycle.
//  States:
//   IDLE:  walk=0, dont_walk=1. Press -> WAIT_RED.
//   WAIT_RED: walk=0, dont_walk=1. red_entry -> WALK (same edge); already-red
//    light does NOT grant; must see a fresh RED entry.
//   WALK:  walk=1, dont_walk=0, req_pending cleared on entry. Second prescaler
//    restarts on entry; exactly WALK_SEC*CLK_PER_SEC cycles, then FLASH.
//   FLASH: walk=0; dont_walk=1 for first CLK_PER_SEC/2 cycles, toggles every
//    CLK_PER_SEC/2 cycles; countdown=FLASH_SEC on entry, -1 per second; after
//    FLASH_SEC*CLK_PER_SEC cycles -> WAIT_RED if req_pending else IDLE;
//    countdown=0, dont_walk=1 steady.
//   FAULT: walk=0, dont_walk=1 steady, countdown=0, fault=1; exit only by reset.
//  Priority each edge: light==11 (any state) -> FAULT > light!=00 while in
//   WALK/FLASH -> abort (conflict pulse, countdown=0, -> WAIT_RED if req_pending
//   else IDLE) > normal transitions.
//  Press during WALK/FLASH sets req_pending (served at next red_entry); press
//   in WAIT_RED is absorbed (already pending). Press on the red_entry edge
//   itself: granted walk consumes it, req_pending ends 0.
//  Prescaler/second counters saturate-free: wrap to 0 on each second boundary.
// TESTING (defaults)
//  Reset: rstb=1 mid-WALK -> same time walk=0, dont_walk=1, countdown=0, req_pending=0.
//  light=01, ped_btn high 6 cyc -> req_pending=1 at edge 5; light->00 -> walk=1
//   40 cyc, FLASH 50 cyc: countdown 5,4,3,2,1 (10 cyc each), dont_walk toggles
//   every 5 cyc starting 1; then IDLE, dont_walk=1, req_pending=0.
//  ped_btn high 2 cyc (glitch) -> req_pending stays 0, no WALK on next red entry.
//  light held 00, press -> WAIT_RED, walk stays 0; light 01 then 00 -> WALK.
//  In WALK cycle 12, light->01 -> next edge walk=0, dont_walk=1, conflict=1 for 1 cyc.
//  light=11 for 1 cyc in FLASH -> fault=1, dont_walk=1 steady; stays after light=00
//   and new presses, until rstb.

Source files
------------

// File: rtl/ped_walk_ctrl.sv
// ped_walk_ctrl: pedestrian WALK/DONT_WALK sequencer slaved to the vehicle light phase
module ped_walk_ctrl #(
  parameter int CLK_PER_SEC = 10,
  parameter int WALK_SEC    = 4,
  parameter int FLASH_SEC   = 5,
  parameter int DEB_CYC     = 3,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [1:0]    light,
  input  logic          ped_btn,
  output logic          walk,
  output logic          dont_walk,
  output logic [CW-1:0] countdown,
  output logic          req_pending,
  output logic          conflict,
  output logic          fault
);
  localparam int PW   = CLK_PER_SEC > 1 ? $clog2(CLK_PER_SEC) : 1;
  localparam int SMAX = WALK_SEC > FLASH_SEC ? WALK_SEC : FLASH_SEC;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int DW   = $clog2(DEB_CYC + 1);

  typedef enum logic [2:0] {IDLE, WAIT_RED, WALK, FLASH, FAULT} state_t;

  state_t          state, state_n, idle_or_wait;
  logic            s1, s2, press, red_entry, active, abort, sec_end, phase_end, req_n;
  logic            walk_d, dont_walk_d, conflict_d, fault_d;
  logic [DW-1:0]   deb;
  logic [1:0]      light_q;
  logic [PW-1:0]   pre, pre_n;
  logic [SW-1:0]   sec, sec_n;
  logic [CW-1:0]   countdown_d;

  // deb saturates at DEB_CYC so a long hold yields a single press
  always_ff @(posedge clk or posedge rstb)
    if (rstb) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= '0;
    end else begin
      s1  <= ped_btn;
      s2  <= s1;
      deb <= !s2 ? '0 : (deb == DW'(DEB_CYC) ? deb : deb + DW'(1));
    end

  always_comb begin
    press        = s2 && deb == DW'(DEB_CYC - 1);
    red_entry    = light == 2'b00 && light_q != 2'b00;
    active       = state == WALK || state == FLASH;
    abort        = active && light != 2'b00 && light != 2'b11;
    sec_end      = pre == PW'(CLK_PER_SEC - 1);
    phase_end    = sec_end && sec == (state == WALK ? SW'(WALK_SEC - 1) : SW'(FLASH_SEC - 1));
    idle_or_wait = (req_pending || press) ? WAIT_RED : IDLE;
  end

  always_comb begin
    state_n = state;
    if (light == 2'b11) state_n = FAULT;
    else if (abort) state_n = idle_or_wait;
    else
      case (state)
        IDLE:     state_n = press ? WAIT_RED : IDLE;
        WAIT_RED: state_n = red_entry ? WALK : WAIT_RED;
        WALK:     state_n = phase_end ? FLASH : WALK;
        FLASH:    state_n = phase_end ? idle_or_wait : FLASH;
        default:  state_n = FAULT;
      endcase
    pre_n = (state_n == state && active) ? (sec_end ? '0 : pre + PW'(1)) : '0;
    sec_n = (state_n == state && active) ? sec + SW'(sec_end) : '0;
    req_n = (state == WAIT_RED && state_n == WALK) ? 1'b0 : (req_pending | press);
  end

  always_comb begin
    walk_d      = state_n == WALK;
    dont_walk_d = state_n == FLASH ? pre_n < PW'(CLK_PER_SEC / 2) : state_n != WALK;
    countdown_d = state_n == FLASH ? CW'(FLASH_SEC) - CW'(sec_n) : '0;
    conflict_d  = abort;
    fault_d     = state_n == FAULT;
  end

  always_ff @(posedge clk or posedge rstb)
    if (rstb) begin
      state       <= IDLE;
      light_q     <= 2'b00;
      pre         <= '0;
      sec         <= '0;
      req_pending <= 1'b0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      countdown   <= '0;
      conflict    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      light_q     <= light;
      pre         <= pre_n;
      sec         <= sec_n;
      req_pending <= req_n;
      walk        <= walk_d;
      dont_walk   <= dont_walk_d;
      countdown   <= countdown_d;
      conflict    <= conflict_d;
      fault       <= fault_d;
    end
endmodule

// File: tb/tb_ped_walk_ctrl.sv
// tb_ped_walk_ctrl: scoreboarded random and directed stimulus against a phase-timer reference model
module tb_ped_walk_ctrl;
  localparam int CPS = 10, WS = 4, FS = 5, DC = 3, CW = 4;
  localparam int ID = 0, WT = 1, WK = 2, FL = 3, FT = 4;

  logic          clk = 1'b0;
  logic          rstb = 1'b1;
  logic [1:0]    light = 2'b00;
  logic          ped_btn = 1'b0;
  logic          walk, dont_walk, req_pending, conflict, fault;
  logic [CW-1:0] countdown;

  ped_walk_ctrl #(.CLK_PER_SEC(CPS), .WALK_SEC(WS), .FLASH_SEC(FS), .DEB_CYC(DC), .CW(CW)) dut (
    .clk(clk), .rstb(rstb), .light(light), .ped_btn(ped_btn), .walk(walk), .dont_walk(dont_walk),
    .countdown(countdown), .req_pending(req_pending), .conflict(conflict), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef logic [CW+4:0] obs_t;
  obs_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   mode, el, r1, r2;
  logic pend, conf;
  logic [1:0] prev;

  function automatic obs_t dut_obs();
    return {walk, dont_walk, countdown, req_pending, conflict, fault};
  endfunction

  function automatic void check(input obs_t got, input obs_t exp, input string name);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t {walk,dont_walk,countdown,req_pending,conflict,fault} got %b required %b",
               name, $time, got, exp);
    end
  endfunction

  // model output: flash blink and countdown derived from elapsed cycles in the phase
  function automatic obs_t expect_now();
    logic w, dw;
    logic [CW-1:0] cd;
    w  = mode == WK;
    dw = mode == FL ? ((el / (CPS / 2)) % 2 == 0) : (mode != WK);
    cd = mode == FL ? CW'(FS - el / CPS) : '0;
    return {w, dw, cd, pend, conf, mode == FT};
  endfunction

  task automatic model_reset();
    mode = ID; el = 0; pend = 1'b0; conf = 1'b0; prev = 2'b00; r1 = 0; r2 = 0;
  endtask

  // r1/r2 are the high-run lengths of the sampled button one and two edges back
  task automatic model_edge(input logic [1:0] l, input logic b);
    logic p, re, was_wt;
    int nr;
    p = r2 == DC;
    re = l == 2'b00 && prev != 2'b00;
    was_wt = mode == WT;
    conf = 1'b0;
    if (l == 2'b11) mode = FT;
    else if ((mode == WK || mode == FL) && l != 2'b00) begin
      conf = 1'b1;
      mode = (pend || p) ? WT : ID;
    end else if (mode == ID && p) mode = WT;
    else if (mode == WT && re) begin mode = WK; el = 0; end
    else if (mode == WK) begin
      el++;
      if (el == WS * CPS) begin mode = FL; el = 0; end
    end else if (mode == FL) begin
      el++;
      if (el == FS * CPS) mode = (pend || p) ? WT : ID;
    end
    pend = (was_wt && mode == WK) ? 1'b0 : (pend | p);
    prev = l;
    nr = b ? r1 + 1 : 0;
    r2 = r1;
    r1 = nr;
  endtask

  task automatic step(input logic [1:0] l, input logic b);
    light = l;
    ped_btn = b;
    @(posedge clk);
    #1;
    model_edge(l, b);
    sb.push_back(expect_now());
  endtask

  task automatic hold(input int n, input logic [1:0] l, input logic b);
    repeat (n) step(l, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rstb = 1'b1;
    light = 2'b00;
    ped_btn = 1'b0;
    model_reset();
    #1;
    check(dut_obs(), expect_now(), "async_reset");
    @(posedge clk);
    #1;
    sb.push_back(expect_now());
    rstb = 1'b0;
  endtask

  task automatic get_walk();
    hold(3, 2'b01, 1'b0);
    hold(6, 2'b01, 1'b1);
    hold(3, 2'b01, 1'b0);
    step(2'b00, 1'b0);
  endtask

  always @(negedge clk)
    if (sb.size() != 0) check(dut_obs(), sb.pop_front(), "outputs");

  initial begin
    logic [1:0] l;
    logic b;
    int chg;
    model_reset();
    do_reset();
    get_walk();
    hold(100, 2'b00, 1'b0);
    hold(3, 2'b01, 1'b0);
    hold(2, 2'b01, 1'b1);
    hold(8, 2'b01, 1'b0);
    hold(50, 2'b00, 1'b0);
    hold(6, 2'b00, 1'b1);
    hold(10, 2'b00, 1'b0);
    hold(3, 2'b01, 1'b0);
    hold(100, 2'b00, 1'b0);
    get_walk();
    hold(11, 2'b00, 1'b0);
    hold(5, 2'b01, 1'b0);
    get_walk();
    hold(10, 2'b00, 1'b0);
    hold(6, 2'b00, 1'b1);
    hold(100, 2'b00, 1'b0);
    hold(3, 2'b10, 1'b0);
    hold(100, 2'b00, 1'b0);
    get_walk();
    hold(15, 2'b00, 1'b0);
    do_reset();
    get_walk();
    hold(45, 2'b00, 1'b0);
    step(2'b11, 1'b0);
    hold(10, 2'b00, 1'b0);
    hold(6, 2'b00, 1'b1);
    hold(10, 2'b00, 1'b0);
    hold(3, 2'b01, 1'b0);
    hold(10, 2'b00, 1'b0);
    do_reset();
    for (int s = 0; s < 15; s++) begin
      l = 2'b01;
      b = 1'b0;
      chg = int'($urandom_range(20, 120));
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, chg) == 0)
          l = (s % 4 == 3 && $urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        if ($urandom_range(0, 5) == 0) b = ~b;
        step(l, b);
      end
      do_reset();
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
